// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator with an in-order prediction-metadata queue.
// The PC and FSM are registered; the queue head is read from registered storage.
module fetch_pc_gen #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h1c00_0000,
  parameter int unsigned            FQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  exRedir,
  input  logic [ADDR_WIDTH-1:0] exRedirPC,
  input  logic [ADDR_WIDTH-1:0] pdPC,
  input  logic                  pdBranch,
  input  logic                  pdReason,
  output logic                  ifVld,
  output logic [ADDR_WIDTH-1:0] ifPC,
  input  logic                  icReady,
  output logic                  fqVld,
  output logic [ADDR_WIDTH-1:0] fqPC,
  output logic [1:0]            fqMask,
  output logic                  fqBranch,
  output logic                  fqReason,
  output logic [ADDR_WIDTH-1:0] fqTar,
  output logic                  fqEpoch,
  output logic                  curEpoch,
  input  logic                  fqPop
);

  localparam int unsigned PtrW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned HiW  = ADDR_WIDTH - 3;
  localparam logic [CntW-1:0] CntFull = CntW'(FQ_DEPTH);

  typedef enum logic [1:0] {StBoot, StRun, StFull} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0]            mask;
    logic                  branch;
    logic                  reason;
    logic [ADDR_WIDTH-1:0] tar;
    logic                  epoch;
  } entry_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  epoch_q, epoch_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  entry_t                mem_q [FQ_DEPTH];
  entry_t                mem_d [FQ_DEPTH];

  logic   fire;
  logic   pop;
  logic   head_vld;
  entry_t push_entry;
  entry_t head;
  logic   unused_redir_lsb;

  assign unused_redir_lsb = ^exRedirPC[1:0];

  assign ifVld    = (state_q == StRun);
  assign ifPC     = pc_q;
  assign curEpoch = epoch_q;
  assign head_vld = (cnt_q != '0);
  assign fire     = ifVld & icReady & ~exRedir;
  assign pop      = fqPop & head_vld & ~exRedir;

  always_comb begin
    push_entry.pc     = pc_q;
    // A taken lower slot squashes the upper word of an aligned pair.
    push_entry.mask   = pc_q[2] ? 2'b10 : ((pdBranch & ~pdReason) ? 2'b01 : 2'b11);
    push_entry.branch = pdBranch;
    push_entry.reason = pdReason;
    push_entry.tar    = pdPC;
    push_entry.epoch  = epoch_q;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epoch_d  = epoch_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    if (exRedir) begin
      pc_d     = {exRedirPC[ADDR_WIDTH-1:2], 2'b00};
      epoch_d  = ~epoch_q;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = StRun;
    end else begin
      if (fire) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
        pc_d = pdBranch ? {pdPC[ADDR_WIDTH-1:2], 2'b00}
                        : {pc_q[ADDR_WIDTH-1:3] + HiW'(1), 3'b000};
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      cnt_d   = cnt_q + CntW'(fire) - CntW'(pop);
      state_d = (cnt_d == CntFull) ? StFull : StRun;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      epoch_q  <= 1'b0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epoch_q  <= epoch_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Head fields read as zero while the queue is empty.
  assign head     = head_vld ? mem_q[rd_ptr_q] : '0;
  assign fqVld    = head_vld;
  assign fqPC     = head.pc;
  assign fqMask   = head.mask;
  assign fqBranch = head.branch;
  assign fqReason = head.reason;
  assign fqTar    = head.tar;
  assign fqEpoch  = head.epoch;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_fetch_pc_gen;

  localparam int          D      = 4;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk, rstn;
  logic        exRedir, pdBranch, pdReason, icReady, fqPop;
  logic [31:0] exRedirPC, pdPC;
  logic        ifVld, fqVld, fqBranch, fqReason, fqEpoch, curEpoch;
  logic [31:0] ifPC, fqPC, fqTar;
  logic [1:0]  fqMask;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic        br;
    logic        rs;
    logic [31:0] tar;
    logic        ep;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_ep;
  bit          m_boot;
  int          n_checks = 0;
  int          n_pass   = 0;

  fetch_pc_gen #(.ADDR_WIDTH(32), .RESET_PC(RST_PC), .FQ_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .exRedir(exRedir), .exRedirPC(exRedirPC),
    .pdPC(pdPC), .pdBranch(pdBranch), .pdReason(pdReason),
    .ifVld(ifVld), .ifPC(ifPC), .icReady(icReady),
    .fqVld(fqVld), .fqPC(fqPC), .fqMask(fqMask), .fqBranch(fqBranch),
    .fqReason(fqReason), .fqTar(fqTar), .fqEpoch(fqEpoch),
    .curEpoch(curEpoch), .fqPop(fqPop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_pc   = RST_PC;
    m_ep   = 1'b0;
    m_boot = 1'b1;
  endtask

  // Applies one clock of the specified behaviour using the inputs now on the pins.
  task automatic model_step();
    bit   can_fetch;
    ent_t e;
    if (rstn) return;
    can_fetch = !m_boot && (m_q.size() < D);
    if (exRedir) begin
      m_pc = exRedirPC & ~32'h3;
      m_q.delete();
      m_ep = ~m_ep;
    end else begin
      if (fqPop && m_q.size() > 0) void'(m_q.pop_front());
      if (can_fetch && icReady) begin
        e.pc   = m_pc;
        e.mask = m_pc[2] ? 2'b10 : ((pdBranch && !pdReason) ? 2'b01 : 2'b11);
        e.br   = pdBranch;
        e.rs   = pdReason;
        e.tar  = pdPC;
        e.ep   = m_ep;
        m_q.push_back(e);
        m_pc = pdBranch ? (pdPC & ~32'h3) : ((m_pc & ~32'h7) + 32'd8);
      end
    end
    m_boot = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exRedir = 0; exRedirPC = '0; pdPC = '0; pdBranch = 0; pdReason = 0;
    icReady = 0; fqPop = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ifVld !== 1'b0) $display("FAIL reset_ifvld got %b want 0", ifVld); else n_pass++;
    n_checks++; if (ifPC !== RST_PC) $display("FAIL reset_ifpc got %h want %h", ifPC, RST_PC); else n_pass++;
    n_checks++; if (fqVld !== 1'b0) $display("FAIL reset_fqvld got %b want 0", fqVld); else n_pass++;
    n_checks++;
    if ({fqMask, fqBranch, fqReason, fqPC, fqTar, fqEpoch} !== '0)
      $display("FAIL reset_head got %h/%h/%b want zeros", fqPC, fqTar, fqMask);
    else n_pass++;
    n_checks++; if (curEpoch !== 1'b0) $display("FAIL reset_epoch got %b want 0", curEpoch); else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset();
    icReady = 1;
    n_checks++; if (ifVld !== 1'b0) $display("FAIL seq_boot got %b want 0", ifVld); else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ifVld !== 1'b1 || ifPC !== RST_PC + 32'(8 * i))
        $display("FAIL seq_pc%0d got %b/%h want 1/%h", i, ifVld, ifPC, RST_PC + 32'(8 * i));
      else n_pass++;
      tick();
    end
    n_checks++; if (ifVld !== 1'b0) $display("FAIL seq_full got %b want 0", ifVld); else n_pass++;
    n_checks++; if (ifPC !== 32'h1c00_0020) $display("FAIL seq_next got %h want 1c000020", ifPC); else n_pass++;
    icReady = 0;
    for (int i = 0; i < 4; i++) begin
      fqPop = 1;
      n_checks++;
      if (fqVld !== 1'b1 || fqPC !== RST_PC + 32'(8 * i) || fqMask !== 2'b11)
        $display("FAIL seq_head%0d got %b/%h/%b want 1/%h/11", i, fqVld, fqPC, fqMask,
                 RST_PC + 32'(8 * i));
      else n_pass++;
      tick();
    end
    fqPop = 0;
    n_checks++; if (fqVld !== 1'b0) $display("FAIL seq_drained got %b want 0", fqVld); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    exRedir = 1; exRedirPC = 32'h1c00_0004;
    tick();
    exRedir = 0; icReady = 1; pdBranch = 1; pdReason = 1; pdPC = 32'h1c00_0100;
    tick();
    icReady = 0; pdBranch = 0;
    n_checks++; if (ifPC !== 32'h1c00_0100) $display("FAIL br_upper_pc got %h want 1c000100", ifPC); else n_pass++;
    n_checks++;
    if (fqMask !== 2'b10 || fqTar !== 32'h1c00_0100 || fqPC !== 32'h1c00_0004 || fqBranch !== 1'b1)
      $display("FAIL br_upper_entry got %b/%h/%h/%b want 10/1c000100/1c000004/1",
               fqMask, fqTar, fqPC, fqBranch);
    else n_pass++;
    exRedir = 1; exRedirPC = 32'h1c00_0010;
    tick();
    exRedir = 0;
    n_checks++; if (fqVld !== 1'b0) $display("FAIL br_flush got %b want 0", fqVld); else n_pass++;
    icReady = 1; pdBranch = 1; pdReason = 0; pdPC = 32'h1c00_0200;
    tick();
    icReady = 0; pdBranch = 0;
    n_checks++; if (ifPC !== 32'h1c00_0200) $display("FAIL br_lower_pc got %h want 1c000200", ifPC); else n_pass++;
    n_checks++; if (fqMask !== 2'b01) $display("FAIL br_lower_mask got %b want 01", fqMask); else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    icReady = 1;
    repeat (4) tick();
    exRedir = 1; exRedirPC = 32'h1c00_0443;
    tick();
    exRedir = 0;
    n_checks++; if (ifPC !== 32'h1c00_0440) $display("FAIL redir_pc got %h want 1c000440", ifPC); else n_pass++;
    n_checks++; if (fqVld !== 1'b0) $display("FAIL redir_flush got %b want 0", fqVld); else n_pass++;
    n_checks++; if (curEpoch !== 1'b1) $display("FAIL redir_epoch got %b want 1", curEpoch); else n_pass++;
    n_checks++; if (ifVld !== 1'b1) $display("FAIL redir_vld got %b want 1", ifVld); else n_pass++;
    tick();
    icReady = 0;
    n_checks++;
    if (fqVld !== 1'b1 || fqEpoch !== 1'b1 || fqPC !== 32'h1c00_0440)
      $display("FAIL redir_push got %b/%b/%h want 1/1/1c000440", fqVld, fqEpoch, fqPC);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    do_reset();
    icReady = 1;
    repeat (5) tick();
    n_checks++; if (ifVld !== 1'b0) $display("FAIL full_enter got %b want 0", ifVld); else n_pass++;
    tick();
    n_checks++; if (ifPC !== 32'h1c00_0020) $display("FAIL full_hold got %h want 1c000020", ifPC); else n_pass++;
    fqPop = 1;
    tick();
    fqPop = 0;
    n_checks++; if (ifVld !== 1'b1) $display("FAIL full_leave got %b want 1", ifVld); else n_pass++;
    tick();
    n_checks++;
    if (ifVld !== 1'b0 || fqPC !== 32'h1c00_0008)
      $display("FAIL full_refill got %b/%h want 0/1c000008", ifVld, fqPC);
    else n_pass++;
    icReady = 0; fqPop = 1;
    tick();
    icReady = 1;
    tick();
    icReady = 0; fqPop = 0;
    n_checks++;
    if (ifVld !== 1'b1 || fqPC !== 32'h1c00_0018)
      $display("FAIL full_pushpop got %b/%h want 1/1c000018", ifVld, fqPC);
    else n_pass++;
    icReady = 1;
    tick();
    icReady = 0;
    n_checks++;
    if (ifVld !== 1'b0 || ifPC !== 32'h1c00_0038)
      $display("FAIL full_again got %b/%h want 0/1c000038", ifVld, ifPC);
    else n_pass++;
  endtask

  task automatic test_stall_wrap();
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ifPC !== RST_PC || fqVld !== 1'b0)
        $display("FAIL stall%0d got %h/%b want %h/0", i, ifPC, fqVld, RST_PC);
      else n_pass++;
      tick();
    end
    exRedir = 1; exRedirPC = 32'hffff_fff8;
    tick();
    exRedir = 0; icReady = 1;
    tick();
    icReady = 0;
    n_checks++; if (ifPC !== 32'h0) $display("FAIL wrap_pc got %h want 00000000", ifPC); else n_pass++;
    n_checks++;
    if (fqPC !== 32'hffff_fff8 || fqMask !== 2'b11)
      $display("FAIL wrap_entry got %h/%b want fffffff8/11", fqPC, fqMask);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    exRedir = 1; exRedirPC = 32'h1c00_0800;
    tick();
    exRedir = 0; icReady = 1;
    repeat (2) tick();
    idle_inputs();
    #3;
    rstn = 1'b1;
    #1;
    n_checks++;
    if (ifPC !== RST_PC || ifVld !== 1'b0 || fqVld !== 1'b0 || curEpoch !== 1'b0 || fqPC !== 32'h0)
      $display("FAIL async_rst got %h/%b/%b/%b want %h/0/0/0", ifPC, ifVld, fqVld, curEpoch, RST_PC);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    n_checks++; if (ifVld !== 1'b0) $display("FAIL async_boot got %b want 0", ifVld); else n_pass++;
    tick();
    n_checks++; if (ifVld !== 1'b1) $display("FAIL async_run got %b want 1", ifVld); else n_pass++;
  endtask

  task automatic test_random();
    bit exp_vld;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      exp_vld = !m_boot && (m_q.size() < D);
      n_checks++;
      if (ifVld !== exp_vld || ifPC !== m_pc || curEpoch !== m_ep)
        $display("FAIL rnd_pc[%0d] got %b/%h/%b want %b/%h/%b", i, ifVld, ifPC, curEpoch,
                 exp_vld, m_pc, m_ep);
      else n_pass++;
      n_checks++;
      if (fqVld !== (m_q.size() != 0))
        $display("FAIL rnd_fqvld[%0d] got %b want %b", i, fqVld, m_q.size() != 0);
      else n_pass++;
      if (m_q.size() != 0) begin
        n_checks++;
        if ({fqPC, fqMask, fqBranch, fqReason, fqTar, fqEpoch} !== m_q[0])
          $display("FAIL rnd_head[%0d] got %h/%b/%b/%b/%h/%b want %h/%b/%b/%b/%h/%b", i,
                   fqPC, fqMask, fqBranch, fqReason, fqTar, fqEpoch,
                   m_q[0].pc, m_q[0].mask, m_q[0].br, m_q[0].rs, m_q[0].tar, m_q[0].ep);
        else n_pass++;
      end
      exRedir   = ($urandom_range(15) == 0);
      exRedirPC = $urandom;
      pdPC      = $urandom;
      pdBranch  = ($urandom_range(3) == 0);
      pdReason  = 1'($urandom_range(1));
      icReady   = ($urandom_range(3) != 0);
      fqPop     = 1'($urandom_range(1));
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rstn = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_redirect();
    test_full_pop();
    test_stall_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Next-PC generator and prediction-metadata queue for the instruction fetch stage. Holds the fetch PC, presents it to `branch_unit` (`ifVld`/`ifPC`), and selects the next PC from the `branch_unit` prediction (`pdPC`/`pdBranch`/`pdReason`), the sequential pair address, or an EX redirect. Issues fetch requests to the I-cache with a valid/ready handshake. Queues the per-fetch prediction metadata in order, for decode to pair with I-cache responses.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `RESET_PC`, 32'h1c00_0000, first fetch address; must be 8-byte aligned.
- `FQ_DEPTH`, 4, metadata queue entries; power of two, ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `rstn` in 1: asynchronous, active-high reset (asserted = 1), released synchronously by the environment.
- `exRedir` in 1: EX redirect (mispredict/flush) this cycle.
- `exRedirPC` in ADDR_WIDTH: redirect target; bits [1:0] ignored.
- `pdPC` in ADDR_WIDTH: predicted target from `branch_unit`.
- `pdBranch` in 1: predictor says taken.
- `pdReason` in 1: 0 = lower slot, 1 = upper slot caused the branch.
- `ifVld` out 1: PC presented this cycle is a real fetch; drives `branch_unit.ifVld`.
- `ifPC` out ADDR_WIDTH: current fetch PC; drives `branch_unit.ifPC` and the I-cache address.
- `icReady` in 1: I-cache accepts the request this cycle.
- `fqVld` out 1: queue head valid.
- `fqPC` out ADDR_WIDTH: PC of the head fetch.
- `fqMask` out 2: head slot-valid mask, bit0 = lower word, bit1 = upper word.
- `fqBranch` out 1: head predicted taken.
- `fqReason` out 1: head prediction reason.
- `fqTar` out ADDR_WIDTH: head predicted target.
- `fqEpoch` out 1: epoch of head entry.
- `curEpoch` out 1: current epoch; decode drops responses whose epoch differs.
- `fqPop` in 1: decode consumes head; ignored when `fqVld`=0.

## Operation
- FSM states: BOOT, RUN, FULL.
  - BOOT: entered on reset. `ifVld`=0. Next cycle → RUN.
  - RUN: `ifVld`=1.
  - FULL: `ifVld`=0, entered when the queue count reaches FQ_DEPTH. Leaves to RUN on the first cycle with count < FQ_DEPTH after pop.
- Fetch fires when `ifVld` & `icReady` & !`exRedir`.
- On fire, push one entry:
  - {`ifPC`, mask, `pdBranch`, `pdReason`, `pdPC`, `curEpoch`}.
  - Base mask: `ifPC[2]`=1 → 2'b10, else 2'b11.
  - If `pdBranch` & !`pdReason` & !`ifPC[2]`, mask = 2'b01 (upper slot squashed).
- Next PC on fire:
  - `pdBranch` → {`pdPC`[ADDR_WIDTH-1:2], 2'b00}.
  - Otherwise {`ifPC`[ADDR_WIDTH-1:3] + 1, 3'b000`}; the increment wraps modulo 2^(ADDR_WIDTH-3).
- No fire and no redirect: PC holds.
- `exRedir` has priority over everything:
  - `ifPC` ← {`exRedirPC`[ADDR_WIDTH-1:2], 2'b00}.
  - Queue emptied and `curEpoch` toggled.
  - No push that cycle.
  - FSM → RUN, including from FULL or BOOT.
- Push and pop in the same cycle: count unchanged, both take effect. A pop with a redirect in the same cycle is subsumed by the flush.
- Reset values:
  - `ifPC`=RESET_PC, state BOOT, `ifVld`=0.
  - Queue empty: `fqVld`=0, `fqMask`=0, `fqBranch`=0, `fqReason`=0, `fqPC`=0, `fqTar`=0, `fqEpoch`=0.
  - `curEpoch`=0.

## Timing
- `ifPC` and the FSM are registered. The predictor output is combinational from `ifPC` and is sampled in the same cycle it is presented.
- Fire at cycle t → new `ifPC` at t+1, entry visible at the head (`fqVld`) at t+1 if the queue was empty.
- Redirect at t → `ifPC`=target and `ifVld`=1 at t+1; `fqVld`=0 at t+1.
- Queue outputs are registered-head reads. No combinational path from `fqPop` or `icReady` to `ifPC`; `ifVld` depends only on state.
- Throughput: one fetch per cycle while not full and `icReady`=1.
- Reset asserted mid-operation: all state returns to reset values asynchronously. BOOT lasts exactly one cycle after release.

## Test plan
- Reset release, `icReady`=1, `pdBranch`=0, no pops:
  - `ifPC` sequence 1c000000 (BOOT, `ifVld`=0), 1c000000, 1c000008, 1c000010, 1c000018.
  - After 4 fires, state FULL and `ifVld`=0.
  - `fqMask`=11 for all entries.
- `ifPC`=1c000004, `pdBranch`=1, `pdPC`=1c000100:
  - Entry mask=10, tar=1c000100.
  - Next `ifPC`=1c000100.
- `ifPC`=1c000010, `pdBranch`=1, `pdReason`=0, `pdPC`=1c000200: entry mask=01, next `ifPC`=1c000200.
- Queue with 3 entries, `exRedir`=1 with `exRedirPC`=1c000443 and `icReady`=1 in the same cycle:
  - Next `ifPC`=1c000440, `fqVld`=0, `curEpoch` toggles 0→1.
  - No push. The next fire pushes an entry with epoch 1.
- FULL, then `fqPop`=1 for one cycle: returns to RUN the next cycle and fires again; count never exceeds 4. A simultaneous push+pop at count 3 keeps count 3.
- `icReady`=0 for 5 cycles: `ifPC` holds, no pushes. `ifPC`=fffffff8 with no branch wraps to 00000000.
